// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial link transmitter and receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int SERIAL_DEFAULT_N  = 8;
  localparam int SERIAL_DEFAULT_OS = 16;

  // Callers zero-extend narrower words to 32 bits.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Oversampled serial frame receiver with a valid/ready word output.
// Optional even parity is enabled with SERIAL_RX_PARITY_EN.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int N  = SERIAL_DEFAULT_N,
  parameter int OS = SERIAL_DEFAULT_OS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         frame_err,
  output logic         parity_err,
  output logic         overrun,
  output logic         busy
);

  localparam int TW = $clog2(OS);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] MID   = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] LAST  = TW'(OS - 1);
  localparam logic [BW-1:0] BLAST = BW'(N - 1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          rx_s;
  logic          accept;
  logic          ferr_d;
  logic          at_last;

  rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign at_last = tick && (tick_cnt_q == LAST);
  assign busy    = (state_q != IDLE);

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    accept     = 1'b0;
    ferr_d     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif
    if (tick && state_q != IDLE)
      tick_cnt_d = tick_cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick && tick_cnt_q == MID) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (at_last) begin
          sh_d = {rx_s, sh_q[N-1:1]};
          if (bit_cnt_q == BLAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (at_last) begin
          par_bad_d = even_parity(32'(sh_q)) ^ rx_s;
          perr_d    = par_bad_d;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (at_last) begin
          state_d = IDLE;
          if (rx_s) begin
`ifdef SERIAL_RX_PARITY_EN
            accept = !par_bad_q;
`else
            accept = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
    end
  end

  // Holding register: a newer word always replaces an unconsumed one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= accept & data_valid & ~data_ready;
      if (accept) begin
        data_out   <= sh_q;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver, N=8, OS=16, tick held high.
module tb_serial_frame_receiver;

  localparam int N  = 8;
  localparam int OS = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tick;
  logic         rx;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  int wide_cnt = 0;
  logic fe_prev = 1'b0;
  logic pe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [N-1:0] sb[$];

  serial_frame_receiver #(.N(N), .OS(OS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      fe_cnt += int'(frame_err);
      pe_cnt += int'(parity_err);
      ov_cnt += int'(overrun);
      if ((frame_err && fe_prev) || (parity_err && pe_prev) ||
          (overrun && ov_prev))
        wide_cnt++;
    end
    fe_prev = frame_err;
    pe_prev = parity_err;
    ov_prev = overrun;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic par,
                            input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < N; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("note: parity bit ignored");
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag);
    logic [N-1:0] exp;
    for (int i = 0; i < 40 && !data_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, 32'(data_out), 32'(exp));
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, pe0;
    reset_n    = 1'b0;
    tick       = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    reset_n = 1'b1;
    idle(4);

    // 0xA5 held until consumed
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    expect_word("a5");
    idle(20);
    check("a5_hold", 32'(data_valid), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    consume();
    check("a5_consumed", 32'(data_valid), 32'd0);

    // start glitch
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_hi", 32'(busy), 32'd1);
    idle(20);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_valid", 32'(data_valid), 32'd0);
    check("glitch_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0),
          32'd0);

    // framing error, then a good frame
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    check("ferr_count", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_valid", 32'(data_valid), 32'd0);
    sb.push_back(8'h3D);
    send_frame(8'h3D, 1'b1, 1'b1);
    expect_word("3d");
    consume();

    // overrun
    ov0 = ov_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1);
    expect_word("ov_11");
    sb.push_back(8'h22);
    send_frame(8'h22, 1'b0, 1'b1);
    expect_word("ov_22");
    check("ov_count", 32'(ov_cnt - ov0), 32'd1);

    // reset during data bit 3, with 0x22 still pending
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);
    ov0 = ov_cnt;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    expect_word("5a");
    check("5a_no_ov", 32'(ov_cnt - ov0), 32'd0);
    consume();

`ifdef SERIAL_RX_PARITY_EN
    pe0 = pe_cnt;
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_word("par_ok");
    check("par_ok_err", 32'(pe_cnt - pe0), 32'd0);
    consume();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("par_bad_err", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_valid", 32'(data_valid), 32'd0);
`else
    check("par_tied", 32'(pe_cnt), 32'd0);
`endif

    check("pulse_width", 32'(wide_cnt), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Deserializing receive stage for the team's serial link: it samples an asynchronous, idle-high serial line at an oversampled rate, detects start/stop framing and shifts N data bits in LSB first. It presents each completed word on a parallel port with a valid/ready handshake. It sits directly downstream of the parallel-load shift register transmitter, whose serial output drives `rx` through the board or link, and feeds word-level consumers such as FIFOs and display logic.

## Interface
- `N`, default 8: data bits per frame.
- `OS`, default 16: oversample ticks per bit. Must be a power of two and at least 4.
- `clk` input, 1 bit: clock; all logic is rising-edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `tick` input, 1 bit: one-cycle strobe at OS × bit rate. It may be held high continuously.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `data_out` output, N bits: last accepted word.
- `data_valid` output, 1 bit: `data_out` holds an unconsumed word.
- `data_ready` input, 1 bit: consumer accepts the word this cycle.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled 0.
- `parity_err` output, 1 bit: one-cycle pulse on parity mismatch. Tied to 0 when parity is compiled out.
- `overrun` output, 1 bit: one-cycle pulse when an unconsumed word is overwritten.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1; `rx_s` is the synchronized value.
- Counters:
  - `tick_cnt`, log2(OS) bits, advances only on `tick`.
  - `bit_cnt`, counts 0..N-1.
- IDLE → START: on `tick` with `rx_s`=0; clear `tick_cnt`.
- START: on the tick where `tick_cnt`=OS/2-1 (start-bit midpoint):
  - `rx_s`=0 → go to DATA and clear both counters.
  - `rx_s`=1 → treat as a glitch and return to IDLE with no flags.
- DATA: on the tick where `tick_cnt`=OS-1:
  - shift right: `sh <= {rx_s, sh[N-1:1]}`, and increment `bit_cnt`;
  - after bit N-1, go to STOP, or to PARITY when parity is compiled in.
- STOP: on the tick where `tick_cnt`=OS-1:
  - `rx_s`=1 → accept the word;
  - `rx_s`=0 → pulse `frame_err` and discard the word;
  - in both cases return to IDLE.
- Accept: `data_out <= sh`, `data_valid <= 1`.
- Overrun: if `data_valid`=1 and `data_ready`=0 in the accept cycle, pulse `overrun`. The newer word replaces the older one.
- Handshake:
  - `data_valid` falls on the clock after a cycle with `data_valid` & `data_ready`.
  - If accept and consume happen in the same cycle, the new word is loaded, `data_valid` stays 1 and there is no overrun.
  - `data_ready` while `data_valid`=0 is ignored.
- Reset mid-frame aborts the frame:
  - FSM returns to IDLE, counters and `sh` clear to 0, synchronizer flops go to 1;
  - the pending word is lost.

## Timing
- Reset values: `data_out`=0; `data_valid`, `frame_err`, `parity_err`, `overrun` and `busy` all 0.
- `rx` to `rx_s` latency is 2 clk.
- Every sample point is at mid-bit: OS/2 ticks after the start edge is detected, then every OS ticks.
- `data_valid`, `frame_err`, `overrun` and `parity_err` assert on the clk edge that processes the stop-bit (or parity) tick, and are visible the following cycle.
- Error pulses are exactly 1 clk wide.
- `busy` rises the clk after the start edge is detected and falls the clk after the stop-bit tick.
- A new start bit is detected on the first tick after returning to IDLE, so back-to-back frames are supported.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- Defined:
  - adds a PARITY state between DATA and STOP, which samples one bit at `tick_cnt`=OS-1;
  - even parity: if XOR(`sh`, parity bit)=1, pulse `parity_err`, suppress accept, still check the stop bit, then return to IDLE.
- Undefined: no PARITY state; the frame is start + N + stop; `parity_err` is constant 0.

## Structure
- Shared package `serial_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `SERIAL_DEFAULT_N`=8 and `SERIAL_DEFAULT_OS`=16;
  - an `even_parity` function.
  - The transmitter uses the same package.
- One sub-module: `rx_sync`, the 2-flop synchronizer with a reset value parameter (here 1).
- The FSM, counters, shift register and output holding register live in the top-level block.

## Test plan
All scenarios use N=8, OS=16 and `tick` held high.
- 0xA5 frame (start 0, bits 1,0,1,0,0,1,0,1, stop 1), `data_ready`=0 → `data_out`=0xA5 with `data_valid`=1, held until `data_ready` pulses, then `data_valid`=0.
- `rx` low for 4 ticks then high → START aborts; `busy` returns to 0; `data_valid` and all error flags stay 0.
- 0x3C frame with stop bit 0 → `frame_err` high for 1 clk; `data_valid` stays 0; the next valid frame 0x3D is accepted.
- Frames 0x11 then 0x22 with `data_ready`=0 → `overrun` pulse at the second accept; `data_out`=0x22.
- `reset_n` low during data bit 3, then a 0x5A frame → all outputs 0 during reset; 0x5A is received correctly after reset.
- With `SERIAL_RX_PARITY_EN`:
  - 0x07 with parity bit 1 → accepted;
  - 0x07 with parity bit 0 → `parity_err` pulse and `data_valid` stays 0.
